// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared definitions for the control sequencer: opcode map,
//             ALU operation codes, sequencer states, flag bit positions and
//             the decoded instruction-class bundle.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  // Architectural opcode map (4-bit core encoding).
  typedef enum logic [3:0] {
    OP_JMP  = 4'b0000,
    OP_JEQ  = 4'b0001,
    OP_JNE  = 4'b0010,
    OP_JLT  = 4'b0011,
    OP_JGE  = 4'b0100,
    OP_ADD  = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_SUB  = 4'b0111,
    OP_LD   = 4'b1000,
    OP_STR  = 4'b1001,
    OP_MOVF = 4'b1010,
    OP_CMP  = 4'b1100,
    OP_LSL  = 4'b1101,
    OP_MOVI = 4'b1110
  } opcode_e;

  // ALU operation codes; all ones is pass-through.
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_LSL  = 3'd3;
  localparam logic [2:0] ALU_PASS = 3'd7;

  // Sequencer states, binary encoded.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Bit positions inside the {N,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  // What EXEC does with the current instruction. Exactly one bit is set.
  typedef struct packed {
    logic wb;    // ALU result / MOVF / MOVI / LSL goes to write-back
    logic ld;    // memory read
    logic st;    // memory write
    logic cmp;   // flag update only
    logic jump;  // conditional or unconditional jump
    logic ill;   // undefined opcode
  } op_class_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode_tbl.sv
// ============================================================================
//  Module   : ctrl_decode_tbl
//  Purpose  : Purely combinational opcode-to-control table.
//  Ports    : op       in   opcode (OPW >= 4; any set bit above bit 3
//                            makes the opcode illegal)
//             alu_op   out  ALU operation code
//             alu_src  out  1 = immediate operand
//             movf     out  write-back source is the flag register
//             cls      out  instruction class for the sequencer
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_decode_tbl
  import ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int ALUOPW = 3
) (
  input  logic [OPW-1:0]    op,
  output logic [ALUOPW-1:0] alu_op,
  output logic              alu_src,
  output logic              movf,
  output op_class_t         cls
);

  logic [3:0] op_lo;
  logic       hi_zero;

  always_comb begin
    op_lo   = op[3:0];
    hi_zero = ((op >> 4) == '0);
    alu_op  = '1;
    alu_src = 1'b0;
    movf    = 1'b0;
    cls     = '0;
    if (!hi_zero) begin
      cls.ill = 1'b1;
    end else begin
      case (op_lo)
        OP_JMP, OP_JEQ, OP_JNE, OP_JLT, OP_JGE: cls.jump = 1'b1;
        OP_ADD: begin alu_op = ALUOPW'(ALU_ADD); cls.wb = 1'b1; end
        OP_XOR: begin alu_op = ALUOPW'(ALU_XOR); cls.wb = 1'b1; end
        OP_SUB: begin alu_op = ALUOPW'(ALU_SUB); cls.wb = 1'b1; end
        // Loads and stores use the adder for base+offset addressing.
        OP_LD:  begin alu_op = ALUOPW'(ALU_ADD); cls.ld = 1'b1; end
        OP_STR: begin alu_op = ALUOPW'(ALU_ADD); cls.st = 1'b1; end
        OP_MOVF: begin movf = 1'b1; cls.wb = 1'b1; end
        OP_CMP: begin alu_op = ALUOPW'(ALU_SUB); cls.cmp = 1'b1; end
        OP_LSL: begin
          alu_op  = ALUOPW'(ALU_LSL);
          alu_src = 1'b1;
          cls.wb  = 1'b1;
        end
        OP_MOVI: begin alu_src = 1'b1; cls.wb = 1'b1; end
        default: cls.ill = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
// ============================================================================
//  Module   : ctrl_sequencer
//  Purpose  : Multi-cycle instruction sequencer FETCH/DECODE/EXEC/MEM/WB with
//             flag register, bounded memory wait and illegal-opcode trap.
//  Ports    : clk, rst_n                   clock, async active-low reset
//             instr_valid/instr_op/instr_ready   opcode handshake
//             alu_flags                    {N,Z} from ALU, sampled in EXEC
//             mem_ack                      memory access complete
//             alu_op/alu_src/movf          registered datapath controls
//             rd_mem/wr_mem                memory requests, held until ack
//             reg_write, pc_load           one-cycle strobes
//             flags_q                      latched {N,Z}
//             illegal, mem_err             one-cycle error pulses
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW         = 4,
  parameter int ALUOPW      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [OPW-1:0]    instr_op,
  output logic              instr_ready,
  input  logic [1:0]        alu_flags,
  input  logic              mem_ack,
  output logic [ALUOPW-1:0] alu_op,
  output logic              alu_src,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic              reg_write,
  output logic              movf,
  output logic              pc_load,
  output logic [1:0]        flags_q,
  output logic              illegal,
  output logic              mem_err
);

  localparam int CNTW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [ALUOPW-1:0] alu_op_q, alu_op_d;
  logic              alu_src_q, alu_src_d;
  logic              movf_q, movf_d;
  logic [1:0]        flags_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [ALUOPW-1:0] tbl_alu_op;
  logic              tbl_alu_src;
  logic              tbl_movf;
  op_class_t         cls;
  logic              jump_taken;

  // The table always looks at the latched opcode, so its outputs are stable
  // from DECODE until the instruction retires.
  ctrl_decode_tbl #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW)
  ) u_decode_tbl (
    .op      (op_q),
    .alu_op  (tbl_alu_op),
    .alu_src (tbl_alu_src),
    .movf    (tbl_movf),
    .cls     (cls)
  );

  // Jump conditions use the latched flags, never the live ALU flags.
  always_comb begin
    case (op_q[3:0])
      OP_JMP:  jump_taken = 1'b1;
      OP_JEQ:  jump_taken = flags_q[FLAG_Z];
      OP_JNE:  jump_taken = !flags_q[FLAG_Z];
      OP_JLT:  jump_taken = flags_q[FLAG_N];
      OP_JGE:  jump_taken = !flags_q[FLAG_N];
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    alu_op_d    = alu_op_q;
    alu_src_d   = alu_src_q;
    movf_d      = movf_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    rd_mem      = 1'b0;
    wr_mem      = 1'b0;
    reg_write   = 1'b0;
    pc_load     = 1'b0;
    illegal     = 1'b0;
    mem_err     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr_op;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_op_d  = tbl_alu_op;
        alu_src_d = tbl_alu_src;
        movf_d    = tbl_movf;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (cls.ill) begin
          illegal = 1'b1;
        end else if (cls.jump) begin
          pc_load = jump_taken;
        end else if (cls.cmp) begin
          flags_d = alu_flags;
        end else if (cls.ld || cls.st) begin
          cnt_d   = '0;
          state_d = ST_MEM;
        end else if (cls.wb) begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        rd_mem = cls.ld;
        wr_mem = cls.st;
        // Saturating: the counter never wraps even if held at the limit.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNTW'(1);
        // An ack arriving on the timeout cycle still wins.
        if (mem_ack) begin
          state_d = cls.ld ? ST_WB : ST_FETCH;
        end else if (cnt_q == CNT_MAX) begin
          mem_err = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Request lines decode directly from state_q, so the async reset drops
  // them immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      alu_op_q  <= '1;
      alu_src_q <= 1'b0;
      movf_q    <= 1'b0;
      flags_q   <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      movf_q    <= movf_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_src = alu_src_q;
  assign movf    = movf_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
// ============================================================================
//  Module   : tb_ctrl_sequencer
//  Purpose  : Scoreboard bench for ctrl_sequencer. The driver issues opcodes,
//             a reference model predicts every observable event (strobe,
//             request-line release) with its cycle, and a monitor compares.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  localparam int MEM_T = 4;
  localparam int K_WB = 0, K_PC = 1, K_ILL = 2, K_ERR = 3, K_RDEND = 4, K_WREND = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [3:0] instr_op = '0;
  logic       instr_ready;
  logic [1:0] alu_flags = '0;
  logic       mem_ack = 1'b0;
  logic [2:0] alu_op;
  logic       alu_src, rd_mem, wr_mem, reg_write, movf, pc_load, illegal, mem_err;
  logic [1:0] flags_q;

  ctrl_sequencer #(.OPW(4), .ALUOPW(3), .MEM_TIMEOUT(MEM_T)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_op(instr_op),
    .instr_ready(instr_ready), .alu_flags(alu_flags), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_src(alu_src), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .reg_write(reg_write), .movf(movf), .pc_load(pc_load), .flags_q(flags_q),
    .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         kind;
    logic [2:0] aop;
    logic       asrc;
    logic       mv;
    logic       chk;
    logic [1:0] fl;
    int         len;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         next_ready = 0;
  logic [1:0] mflags = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input int k, input logic [2:0] aop, input logic asrc,
                      input logic mv, input logic ck, input int len);
    exp_t e;
    e.cyc = c; e.kind = k; e.aop = aop; e.asrc = asrc; e.mv = mv; e.chk = ck;
    e.fl = mflags; e.len = len;
    exp_q.push_back(e);
  endtask

  // Reference model: from the opcode, held flags and memory delay d (ack in
  // MEM cycle d, counted from 0; d > MEM_T means no ack) predict the events
  // relative to acceptance cycle a, and the next cycle ready is 1 again.
  task automatic model(input logic [3:0] op, input logic [1:0] fl, input int d, input int a,
                       output int ack_c, output int nr);
    logic       is_ld;
    logic       taken;
    ack_c = -1;
    nr    = a + 3;
    if (op <= 4'd4) begin
      case (op)
        4'd0:    taken = 1'b1;
        4'd1:    taken = mflags[0];
        4'd2:    taken = !mflags[0];
        4'd3:    taken = mflags[1];
        default: taken = !mflags[1];
      endcase
      if (taken) push(a + 2, K_PC, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    end else if (op == 4'b1100) begin
      mflags = fl;
    end else if (op == 4'b1011 || op == 4'b1111) begin
      push(a + 2, K_ILL, 3'd0, 1'b0, 1'b0, 1'b0, 0);
    end else if (op == 4'b1000 || op == 4'b1001) begin
      is_ld = (op == 4'b1000);
      if (d <= MEM_T) begin
        ack_c = a + 3 + d;
        push(a + 4 + d, is_ld ? K_RDEND : K_WREND, 3'd0, 1'b0, 1'b0, 1'b0, d + 1);
        if (is_ld) push(a + 4 + d, K_WB, 3'd0, 1'b0, 1'b0, 1'b0, 0);
        nr = is_ld ? a + 5 + d : a + 4 + d;
      end else begin
        push(a + 3 + MEM_T, K_ERR, 3'd0, 1'b0, 1'b0, 1'b0, 0);
        push(a + 4 + MEM_T, is_ld ? K_RDEND : K_WREND, 3'd0, 1'b0, 1'b0, 1'b0, MEM_T + 1);
        nr = a + 4 + MEM_T;
      end
    end else begin
      nr = a + 4;
      case (op)
        4'b0101: push(a + 3, K_WB, ALU_ADD, 1'b0, 1'b0, 1'b1, 0);
        4'b0110: push(a + 3, K_WB, ALU_XOR, 1'b0, 1'b0, 1'b1, 0);
        4'b0111: push(a + 3, K_WB, ALU_SUB, 1'b0, 1'b0, 1'b1, 0);
        4'b1101: push(a + 3, K_WB, ALU_LSL, 1'b1, 1'b0, 1'b1, 0);
        4'b1110: push(a + 3, K_WB, 3'b111, 1'b1, 1'b0, 1'b1, 0);
        default: push(a + 3, K_WB, 3'd0, 1'b0, 1'b1, 1'b0, 0);  // MOVF
      endcase
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] fl, input int d);
    int a, ack_c, nr;
    int gap;
    gap = $urandom_range(0, 1);
    repeat (gap) begin
      instr_valid = 1'b0; instr_op = 4'($urandom); alu_flags = 2'($urandom); mem_ack = 1'b0;
      step();
    end
    a = cyc;
    instr_valid = 1'b1; instr_op = op; alu_flags = fl; mem_ack = 1'b0;
    chk("instr_ready_at_issue", 32'(instr_ready), 32'd1);
    model(op, fl, d, a, ack_c, nr);
    next_ready = nr;
    step();
    // While busy, junk on the fetch port and on alu_flags must be ignored.
    while (cyc < nr) begin
      instr_valid = 1'($urandom);
      instr_op    = 4'($urandom);
      alu_flags   = (cyc == a + 2) ? fl : 2'($urandom);
      mem_ack     = (cyc == ack_c);
      step();
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  int   run_rd = 0, run_wr = 0;

  task automatic check_evt(input int kind, input int len);
    exp_t e;
    logic ok;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required no event", kind, cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.cyc == cyc) && (e.kind == kind) && (flags_q == e.fl);
    if (kind == K_RDEND || kind == K_WREND) ok = ok && (len == e.len);
    if (kind == K_WB) ok = ok && (movf == e.mv) && (!e.chk || (alu_op == e.aop && alu_src == e.asrc));
    if (!ok) begin
      n_fail++;
      $display("FAIL event: got kind=%0d cyc=%0d flags=%b len=%0d alu_op=%b src=%b movf=%b, required kind=%0d cyc=%0d flags=%b len=%0d alu_op=%b src=%b movf=%b",
               kind, cyc, flags_q, len, alu_op, alu_src, movf,
               e.kind, e.cyc, e.fl, e.len, e.aop, e.asrc, e.mv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b0; prev_wr = 1'b0; run_rd = 0; run_wr = 0;
    end else begin
      if (prev_rd && !rd_mem) check_evt(K_RDEND, run_rd);
      if (prev_wr && !wr_mem) check_evt(K_WREND, run_wr);
      run_rd  = rd_mem ? run_rd + 1 : 0;
      run_wr  = wr_mem ? run_wr + 1 : 0;
      prev_rd = rd_mem;
      prev_wr = wr_mem;
      if (reg_write) check_evt(K_WB, 0);
      if (pc_load)   check_evt(K_PC, 0);
      if (illegal)   check_evt(K_ILL, 0);
      if (mem_err)   check_evt(K_ERR, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a;
    repeat (3) step();
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_alu_op", 32'(alu_op), 32'h7);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_strobes", 32'({alu_src, rd_mem, wr_mem, reg_write, movf, pc_load, illegal, mem_err}), 32'd0);
    rst_n = 1'b1;
    next_ready = cyc;

    issue(4'b0101, 2'b00, 0);          // ADD
    issue(4'b1100, 2'b01, 0);          // CMP -> Z=1
    issue(4'b0001, 2'b10, 0);          // JEQ taken
    issue(4'b0010, 2'b10, 0);          // JNE not taken
    issue(4'b1000, 2'b00, 4);          // LD, ack on the timeout cycle
    issue(4'b1001, 2'b00, 99);         // STR, no ack -> timeout
    issue(4'b1001, 2'b00, MEM_T - 1);  // STR, ack just before timeout
    issue(4'b1000, 2'b00, 0);          // LD, immediate ack
    issue(4'b1111, 2'b00, 0);          // illegal
    issue(4'b1011, 2'b00, 0);          // illegal
    issue(4'b1101, 2'b00, 0);          // LSL
    issue(4'b1110, 2'b00, 0);          // MOVI
    issue(4'b1010, 2'b00, 0);          // MOVF
    repeat (80) issue(4'($urandom), 2'($urandom), int'($urandom_range(0, MEM_T + 2)));

    // Reset in the middle of a load.
    issue(4'b1100, 2'b11, 0);
    a = cyc;
    instr_valid = 1'b1; instr_op = 4'b1000;
    step();
    instr_valid = 1'b0;
    while (cyc < a + 4) step();
    @(negedge clk); #1;
    chk("rd_before_reset", 32'(rd_mem), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rd_async_drop", 32'(rd_mem), 32'd0);
    chk("ready_in_reset", 32'(instr_ready), 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_reset_flags", 32'(flags_q), 32'd0);
    chk("post_reset_ready", 32'(instr_ready), 32'd1);
    chk("post_reset_rd", 32'(rd_mem), 32'd0);
    mflags = 2'b00;
    next_ready = cyc;
    issue(4'b0001, 2'b11, 0);          // JEQ with cleared Z: not taken
    issue(4'b0100, 2'b00, 0);          // JGE with cleared N: taken
    issue(4'b0111, 2'b00, 0);          // SUB

    repeat (4) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
